// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction fetch / data) arbiter onto a single memory port, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for alternating priority; otherwise the data port always wins.
module mem_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state_reg, state_next;
  logic        owner_reg;            // 0 = instruction port, 1 = data port
  logic        we_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  be_reg;
  logic        sel_d;
  logic [1:0]  gnt_vec;
  logic [1:0]  rvalid_vec;
  logic [31:0] rdata_vec [2];

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_owner_reg <= 1'b0;
    else if (state_reg == RESP && m_rvalid)
      last_owner_reg <= owner_reg;
  end

  // On contention the port that did not complete last goes first.
  assign sel_d = d_req && (!i_req || !last_owner_reg);
`else
  assign sel_d = d_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_req || d_req) state_next = REQ;
      REQ:     if (m_gnt)          state_next = RESP;
      RESP:    if (m_rvalid)       state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request is captured once in IDLE; requester inputs are don't-care afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_reg <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
    end else if (state_reg == IDLE && (i_req || d_req)) begin
      owner_reg <= sel_d;
      we_reg    <= sel_d & d_we;
      addr_reg  <= sel_d ? d_addr  : i_addr;
      wdata_reg <= sel_d ? d_wdata : 32'h0;
      be_reg    <= sel_d ? d_be    : 4'hF;
    end
  end

  always_comb begin
    busy       = (state_reg != IDLE);
    m_req      = 1'b0;
    m_we       = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    m_be       = '0;
    gnt_vec    = '0;
    rvalid_vec = '0;
    case (state_reg)
      REQ: begin
        m_req   = 1'b1;
        m_we    = we_reg;
        m_addr  = addr_reg;
        m_wdata = wdata_reg;
        m_be    = be_reg;
        if (m_gnt) gnt_vec[owner_reg] = 1'b1;
      end
      RESP: begin
        if (m_rvalid) rvalid_vec[owner_reg] = 1'b1;
      end
      default: ;
    endcase
  end

  // Read data is forced to zero on any port not currently receiving a response.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
      assign rdata_vec[gi] = rvalid_vec[gi] ? m_rdata : 32'h0;
    end
  endgenerate

  assign i_gnt    = gnt_vec[0];
  assign d_gnt    = gnt_vec[1];
  assign i_rvalid = rvalid_vec[0];
  assign d_rvalid = rvalid_vec[1];
  assign i_rdata  = rdata_vec[0];
  assign d_rdata  = rdata_vec[1];

endmodule
